modulator_gain_sequencer: RTL
=============================

MODULATOR_GAIN_SEQUENCER -- requirements
Module: modulator_gain_sequencer

Interface
REQ-001 SHALL have parameter inout_width, default 16: width of modulators, period and gained outputs.
REQ-002 SHALL have parameter inout_decimal_width, default 15: fractional bits of mod_* (Q1.15).
REQ-003 aclk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 pwm_period  in  inout_width signed  PWM period in counts.
REQ-006 mod_a, mod_b, mod_c  in  inout_width signed each  phase modulators, Q1.15.
REQ-007 mod_valid  in  1  request to gain one modulator set.
REQ-008 mod_ready  out  1  sequencer can accept a set.
REQ-009 pwm_sync  in  1  one-cycle pulse at the PWM period boundary.
REQ-010 mod_a_gained, mod_b_gained, mod_c_gained  out  inout_width signed each  gained modulators, counts.
REQ-011 gained_valid  out  1  one-cycle pulse: outputs updated this cycle.
REQ-012 overrun  out  1  sticky: an untransferred result set was overwritten.

Function
REQ-013 FSM states SHALL be IDLE, PH_A, PH_B, PH_C; mod_ready SHALL be 1 only in IDLE.
REQ-014 Handshake: on an edge with mod_valid=1 and mod_ready=1, SHALL capture mod_a/b/c and pwm_period into input registers and go to PH_A; mod_valid while not ready SHALL be ignored (no queueing).
REQ-015 Transitions SHALL be PH_A->PH_B->PH_C->IDLE, one cycle each, unconditional.
REQ-016 A single shared signed multiplier (inout_width x inout_width -> 2*inout_width) SHALL serve all phases; operand mux selects captured mod_x by state, always times captured period.
REQ-017 Per phase, product SHALL be arithmetic-right-shifted by inout_decimal_width, then saturated to [-2^(W-1), 2^(W-1)-1], and written to shadow_x on the edge leaving PH_x.
REQ-018 On the edge leaving PH_C, pending SHALL be set to 1; if pending was already 1, overrun SHALL be set and stay set until reset.
REQ-019 On an edge where pwm_sync=1 and pending=1 (value before the edge), outputs SHALL load shadow_a/b/c, gained_valid SHALL be 1 for the following cycle, pending SHALL clear.
REQ-020 pwm_sync coincident with the edge leaving PH_C SHALL NOT transfer that set (pending still 0); transfer occurs on the next pwm_sync.
REQ-021 pwm_sync with pending=0 SHALL leave outputs unchanged and gained_valid=0.
REQ-022 Minimum latency: handshake edge k -> pending set at edge k+3 -> outputs at first pwm_sync edge >= k+4.
REQ-023 Back-to-back: a new handshake SHALL be accepted in the cycle IDLE is re-entered (throughput one set per 4 cycles).
REQ-024 Gained outputs SHALL hold their value between transfers (never glitch with shadow writes).

Reset
REQ-025 resetn=0 SHALL asynchronously force: state IDLE, all input/shadow/output registers 0, pending 0, gained_valid 0, overrun 0; mod_ready SHALL read 1 after release.
REQ-026 Reset mid-sequence SHALL abandon the sequence; no partial set SHALL ever reach the outputs.

Structure
REQ-027 FSM state encoding (IDLE, PH_A, PH_B, PH_C) and saturation bound constants SHALL live in a shared motor-control package.
REQ-028 Scale-and-saturate SHALL be one sub-module, gain_scale_sat (product in, W-bit saturated out, combinational), reused by later gain blocks.

Verification
REQ-029 mod_a=16384, mod_b=-16384, mod_c=0, period=1000, pwm_sync 10 cycles later -> outputs 500, -500, 0, gained_valid one pulse.
REQ-030 mod_a=-32768, period=-32768 -> mod_a_gained=32767 (saturated); mod_a=-32768, period=1000 -> -1000.
REQ-031 pwm_sync on the PH_C exit edge -> no update; next pwm_sync -> update with that set.
REQ-032 two full sequences with no pwm_sync between -> overrun=1, next pwm_sync delivers the second set only.
REQ-033 resetn low during PH_B -> all outputs 0, mod_ready=1 after release, later pwm_sync yields no gained_valid.
REQ-034 mod_valid held high continuously -> handshakes exactly every 4 cycles; mod_valid during PH_A..PH_C ignored.

Source files
------------

// File: rtl/modulator_gain_sequencer_pkg.sv
// Shared motor-control definitions: sequencer state encoding and the
// saturation bounds used by every gain/scale stage.
package modulator_gain_sequencer_pkg;

  // Phase sequencer states; one multiplier pass per phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH_A = 2'd1,
    ST_PH_B = 2'd2,
    ST_PH_C = 2'd3
  } seq_state_e;

  // Widest output the bound helpers below are meant to cover.
  localparam int unsigned SAT_MAX_WIDTH = 32;

  // Largest value representable in a signed field of the given width.
  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed field of the given width.
  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/modulator_gain_sequencer_gain_scale_sat.sv
// Combinational scale-and-saturate: drops the fractional bits of a
// full-width signed product and clamps the result to the output width.
module gain_scale_sat
  import modulator_gain_sequencer_pkg::*;
#(
  parameter int inout_width         = 16,
  parameter int inout_decimal_width = 15
) (
  input  logic signed [2*inout_width-1:0] product_i,
  output logic signed [inout_width-1:0]   sat_o
);

  localparam logic signed [63:0] SAT_HI = sat_max(inout_width);
  localparam logic signed [63:0] SAT_LO = sat_min(inout_width);

  logic signed [2*inout_width-1:0] shifted;
  logic signed [63:0]              shifted_ext;

  // Arithmetic shift keeps the sign (floor toward minus infinity).
  assign shifted     = product_i >>> inout_decimal_width;
  assign shifted_ext = 64'(shifted);

  // Clamp into the signed output range.
  always_comb begin
    sat_o = inout_width'(shifted_ext);
    if (shifted_ext > SAT_HI) begin
      sat_o = inout_width'(SAT_HI);
    end else if (shifted_ext < SAT_LO) begin
      sat_o = inout_width'(SAT_LO);
    end
  end

endmodule

// File: rtl/modulator_gain_sequencer.sv
// Gains a captured set of three Q1.15 phase modulators by the PWM period
// using one shared multiplier over three cycles, then hands the finished
// set to the outputs only at a PWM period boundary.
module modulator_gain_sequencer
  import modulator_gain_sequencer_pkg::*;
#(
  parameter int inout_width         = 16,
  parameter int inout_decimal_width = 15
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic signed [inout_width-1:0] pwm_period,
  input  logic signed [inout_width-1:0] mod_a,
  input  logic signed [inout_width-1:0] mod_b,
  input  logic signed [inout_width-1:0] mod_c,
  input  logic                          mod_valid,
  output logic                          mod_ready,
  input  logic                          pwm_sync,
  output logic signed [inout_width-1:0] mod_a_gained,
  output logic signed [inout_width-1:0] mod_b_gained,
  output logic signed [inout_width-1:0] mod_c_gained,
  output logic                          gained_valid,
  output logic                          overrun
);

  seq_state_e state_q;

  logic signed [inout_width-1:0] mod_a_q, mod_b_q, mod_c_q, period_q;
  logic signed [inout_width-1:0] shadow_a_q, shadow_b_q, shadow_c_q;
  logic signed [inout_width-1:0] out_a_q, out_b_q, out_c_q;
  logic                          pending_q;
  logic                          gained_valid_q;
  logic                          overrun_q;

  logic signed [inout_width-1:0]   mul_op;
  logic signed [2*inout_width-1:0] product;
  logic signed [inout_width-1:0]   scaled;

  // Operand select: the phase being processed picks its captured modulator.
  always_comb begin
    mul_op = mod_c_q;
    case (state_q)
      ST_PH_A: mul_op = mod_a_q;
      ST_PH_B: mul_op = mod_b_q;
      default: mul_op = mod_c_q;
    endcase
  end

  assign product = mul_op * period_q;

  gain_scale_sat #(
    .inout_width        (inout_width),
    .inout_decimal_width(inout_decimal_width)
  ) u_scale_sat (
    .product_i(product),
    .sat_o    (scaled)
  );

  // Sequencer FSM plus shadow/output transfer; outputs change only when a
  // complete set is pending at a PWM boundary, so shadow writes never leak.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      mod_a_q        <= '0;
      mod_b_q        <= '0;
      mod_c_q        <= '0;
      period_q       <= '0;
      shadow_a_q     <= '0;
      shadow_b_q     <= '0;
      shadow_c_q     <= '0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_c_q        <= '0;
      pending_q      <= 1'b0;
      gained_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      gained_valid_q <= 1'b0;

      // Transfer uses the pending flag from before this edge, so a set that
      // completes on this same edge waits for the next boundary.
      if (pwm_sync && pending_q) begin
        out_a_q        <= shadow_a_q;
        out_b_q        <= shadow_b_q;
        out_c_q        <= shadow_c_q;
        gained_valid_q <= 1'b1;
        pending_q      <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (mod_valid) begin
            mod_a_q  <= mod_a;
            mod_b_q  <= mod_b;
            mod_c_q  <= mod_c;
            period_q <= pwm_period;
            state_q  <= ST_PH_A;
          end
        end
        ST_PH_A: begin
          shadow_a_q <= scaled;
          state_q    <= ST_PH_B;
        end
        ST_PH_B: begin
          shadow_b_q <= scaled;
          state_q    <= ST_PH_C;
        end
        ST_PH_C: begin
          shadow_c_q <= scaled;
          state_q    <= ST_IDLE;
          // Later assignment wins over the transfer clear above.
          pending_q  <= 1'b1;
          if (pending_q) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mod_ready    = (state_q == ST_IDLE);
  assign mod_a_gained = out_a_q;
  assign mod_b_gained = out_b_q;
  assign mod_c_gained = out_c_q;
  assign gained_valid = gained_valid_q;
  assign overrun      = overrun_q;

endmodule
